hex_page_display: RTL and testbench
===================================

Name: hex_page_display

Overview:
- Parametrised board-level display controller that drives NUM_DIGITS seven-segment digits from a DATA_W-bit value.
- Captures the value under a level-sensitive load switch.
- When DATA_W exceeds 4*NUM_DIGITS, a debounced push-button pages through the value one digit-window at a time.
- Sits between any datapath under test (ALU, register file, etc.) and the HEX/KEY/SW pins of the FPGA board.

Parameters:
- DATA_W, 64: width of the displayed value (≥1).
- NUM_DIGITS, 8: number of seven-segment digits driven.
- DB_CYCLES, 500000: stable-input cycles required to accept a button change (10 ms at 50 MHz).
- Derived, not overridable:
  - NUM_PAGES = ceil(DATA_W / (4*NUM_DIGITS)).
  - PAGE_W = max(1, clog2(NUM_PAGES)).

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- data_in  in  DATA_W  value to display.
- load  in  1  level; while high the capture register follows data_in every cycle.
- page_btn  in  1  raw push-button, active-low (pressed = 0), asynchronous to CLOCK_50.
- lzb_mode  in  1  leading-zero blanking request (see Optional Feature).
- hex_out  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a}; digit d occupies [7d+6:7d].
- page_idx  out  PAGE_W  currently displayed page.

Behaviour:
- Clock and reset:
  - One clock domain (CLOCK_50).
  - RST is synchronous and active-high; it is sampled only on the rising edge.
- Reset values:
  - Capture register 0.
  - page_idx 0.
  - Sync flops and debounced state 1 (released).
  - Debounce counter 0.
  - hex_out all 7'h7F (blank).
- Capture:
  - If load = 1, cap <= data_in, else cap holds.
- Display path:
  - hex_out is registered from cap and page_idx.
  - Latency from data_in sampled with load = 1 to hex_out updated: 2 cycles.
- Digit mapping:
  - Digit d of page p shows nibble cap[4*(p*NUM_DIGITS+d) +: 4].
  - Bits at or beyond DATA_W read as 0 (partial top nibble is zero-extended).
- Segment table (active-low):
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30
  - 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78
  - 8→7'h00, 9→7'h10, A→7'h08, b→7'h03
  - C→7'h27, d→7'h21, E→7'h06, F→7'h0E
  - Blank → 7'h7F.
- Button synchroniser:
  - page_btn passes through a 2-flop synchroniser to give sync.
- Debounce counter:
  - If sync == stable, cnt <= 0.
  - Else if cnt == DB_CYCLES-1, stable <= sync and cnt <= 0.
  - Else cnt <= cnt+1.
  - Counter width is clog2(DB_CYCLES+1).
- Press event:
  - One-cycle pulse when stable goes 1→0.
  - A held button yields exactly one press.
  - The 0→1 release produces no event.
- Paging:
  - On press, page_idx <= (page_idx == NUM_PAGES-1) ? 0 : page_idx+1.
  - If NUM_PAGES == 1, page_idx stays 0.
- Simultaneous events:
  - A load and a press on the same edge both take effect.
  - The following cycle's hex_out reflects the new page of the new value.
- Reset mid-operation:
  - RST during debounce or during a held press clears cnt and restores stable = 1.
  - page_idx returns to 0.
  - No press event is produced by the reset itself.
  - hex_out is blank for exactly the reset cycle(s), then shows the decoded cap (0) on the first cycle after RST deasserts.

Optional Feature:
- Macro: HEX_LZB_EN.
- Defined, lzb_mode = 1:
  - On the current page, every digit more significant than the highest non-zero digit of that page outputs 7'h7F.
  - Digit 0 is never blanked, so an all-zero page shows a single 0.
  - Blanking is computed in the same registered stage, so latency is unchanged.
- Defined, lzb_mode = 0: behaviour identical to the undefined case.
- Undefined: lzb_mode is ignored and no blanking logic is synthesised.

Test Plan:
- Setting: DB_CYCLES = 4 unless stated.
- Scenario 1, load and display:
  - Stimulus: RST for 2 cycles; load = 1 with data_in = 64'h0123_4567_89AB_CDEF for 1 cycle.
  - Response: 2 cycles later digits 7..0 = 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E; page_idx = 0.
- Scenario 2, paging and wrap:
  - Stimulus: hold page_btn = 0 for 10 cycles, then release.
  - Response: page_idx = 1 after synchroniser + 4 stable cycles; digits show 01234567 (digit 0 = 7'h78, digit 7 = 7'h40). A second press wraps page_idx to 0.
- Scenario 3, bounce rejection:
  - Stimulus: toggle page_btn every 2 cycles for 20 cycles, then hold it at 1.
  - Response: page_idx stays 0 and no press event occurs.
- Scenario 4, hold without load:
  - Stimulus: load = 0 while data_in changes to 64'hFFFF_FFFF_FFFF_FFFF.
  - Response: hex_out is unchanged.
- Scenario 5, narrow width with blanking:
  - Without macro, DATA_W = 40, value 40'hAB_0000_0000, page 1: digits 1,0 = 7'h08, 7'h03; digits 7..2 = 7'h40.
  - With HEX_LZB_EN, lzb_mode = 1, value 5, page 0: digit 0 = 7'h12, digits 7..1 = 7'h7F.
  - With HEX_LZB_EN, lzb_mode = 1, value 0, page 0: digit 0 = 7'h40.
- Scenario 6, reset mid-press:
  - Stimulus: page_btn = 0 for 3 cycles, RST for 1 cycle, page_btn held 0 afterward.
  - Response: hex_out = all 7'h7F in the reset cycle; page_idx = 0 with no advance from the aborted count. The continued hold then yields exactly one advance after 4 more stable cycles.

Source files
------------

// File: rtl/hex_page_display.sv
// -----------------------------------------------------------------------------
// hex_page_display
//
// Board-level display controller. It captures a DATA_W-bit value while `load`
// is high and shows it on NUM_DIGITS active-low seven-segment digits. When the
// value is wider than the digit window, a debounced push-button steps through
// the value one window (page) at a time, wrapping back to page 0 after the last.
//
// Optional feature (compile-time macro HEX_LZB_EN):
//   When defined and lzb_mode = 1, digits above the highest non-zero digit of
//   the current page are blanked. Digit 0 is never blanked. When the macro is
//   undefined, lzb_mode is ignored and no blanking logic exists.
//
// Parameters:
//   DATA_W      width of the displayed value (>= 1)
//   NUM_DIGITS  number of seven-segment digits driven
//   DB_CYCLES   consecutive stable cycles needed to accept a button change
//
// Ports:
//   CLOCK_50  in   system clock, all state on the rising edge
//   RST       in   synchronous, active-high reset
//   data_in   in   value to display
//   load      in   level; while high the capture register follows data_in
//   page_btn  in   raw push-button, active-low, asynchronous to CLOCK_50
//   lzb_mode  in   leading-zero blanking request (HEX_LZB_EN builds only)
//   hex_out   out  active-low segments {g,f,e,d,c,b,a}; digit d at [7d+6:7d]
//   page_idx  out  currently displayed page
// -----------------------------------------------------------------------------
module hex_page_display #(
    parameter  int DATA_W     = 64,
    parameter  int NUM_DIGITS = 8,
    parameter  int DB_CYCLES  = 500000,
    localparam int PAGE_BITS  = 4 * NUM_DIGITS,
    localparam int NUM_PAGES  = (DATA_W + PAGE_BITS - 1) / PAGE_BITS,
    localparam int PAGE_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RST,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    load,
    input  logic                    page_btn,
    input  logic                    lzb_mode,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [PAGE_W-1:0]       page_idx
);

    localparam int         CNT_W = $clog2(DB_CYCLES + 1);
    localparam int         EXT_W = NUM_PAGES * PAGE_BITS;
    localparam logic [6:0] BLANK = 7'h7F;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h27;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [DATA_W-1:0]       cap;
    logic [EXT_W-1:0]        cap_ext;
    logic [PAGE_BITS-1:0]    window;
    logic [7*NUM_DIGITS-1:0] hex_next;

    logic                    sync_meta;
    logic                    sync;
    logic                    stable;
    logic [CNT_W-1:0]        cnt;
    logic                    press;

    // Zero-extend so a partial top page reads missing nibble bits as 0.
    assign cap_ext = EXT_W'(cap);

    // The debounced level is about to fall 1->0 on this edge: that edge is the
    // single press event. Releases (0->1) never generate one.
    assign press = stable && !sync && (cnt == CNT_W'(DB_CYCLES - 1));

    // Select the digit window of the current page.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        window = cap_ext[PAGE_BITS-1:0];
        for (int p = 1; p < NUM_PAGES; p++) begin
            if (page_idx == PAGE_W'(p)) begin
                window = cap_ext[p*PAGE_BITS +: PAGE_BITS];
            end
        end
    end

`ifdef HEX_LZB_EN
    logic lzb_seen;
`else
    logic lzb_unused;
    assign lzb_unused = lzb_mode;
`endif

    // Decode every digit, then (optionally) blank leading zeros scanning down
    // from the most significant digit. Digit 0 is excluded from the scan.
    always_comb begin
        hex_next = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            hex_next[7*d +: 7] = seg7(window[4*d +: 4]);
        end
`ifdef HEX_LZB_EN
        lzb_seen = 1'b0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            if (window[4*d +: 4] != 4'h0) begin
                lzb_seen = 1'b1;
            end
            if (lzb_mode && !lzb_seen) begin
                hex_next[7*d +: 7] = BLANK;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flip-flops.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            cap       <= '0;
            page_idx  <= '0;
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            stable    <= 1'b1;
            cnt       <= '0;
            hex_out   <= {NUM_DIGITS{BLANK}};
        end else begin
            // Two-flop synchroniser for the asynchronous button.
            sync_meta <= page_btn;
            sync      <= sync_meta;

            if (load) begin
                cap <= data_in;
            end

            // Accept a new button level only after DB_CYCLES consecutive
            // cycles of disagreement with the current debounced level.
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // With a single page the compare is always true, pinning page 0.
            if (press) begin
                page_idx <= (page_idx == PAGE_W'(NUM_PAGES - 1)) ? '0
                                                                 : page_idx + PAGE_W'(1);
            end

            hex_out <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_page_display.sv
// -----------------------------------------------------------------------------
// tb_hex_page_display
//
// Drives two instances of hex_page_display from the same controls: a 64-bit
// one and a 40-bit one (partial top page), both with DB_CYCLES = 4. A
// behavioural model (nibble arithmetic, a sample delay line and a sliding
// window of debounce samples) predicts hex_out and page_idx every cycle.
// Directed steps for the documented scenarios are followed by random traffic.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_hex_page_display;

    localparam int NUM_DIGITS = 8;
    localparam int DB         = 4;
    localparam int W_WIDE     = 64;
    localparam int W_NARROW   = 40;
    localparam int PAGES_WIDE   = (W_WIDE + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);
    localparam int PAGES_NARROW = (W_NARROW + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                        7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03,
                                        7'h27, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        btn;
    logic        lzb;
    logic [63:0] data;

    logic [55:0] hex_w;
    logic [55:0] hex_n;
    logic [0:0]  page_w;
    logic [0:0]  page_n;

    always #5 clk = ~clk;

    hex_page_display #(.DATA_W(W_WIDE), .NUM_DIGITS(NUM_DIGITS), .DB_CYCLES(DB)) dut_wide (
        .CLOCK_50 (clk),
        .RST      (rst),
        .data_in  (data),
        .load     (load),
        .page_btn (btn),
        .lzb_mode (lzb),
        .hex_out  (hex_w),
        .page_idx (page_w)
    );

    hex_page_display #(.DATA_W(W_NARROW), .NUM_DIGITS(NUM_DIGITS), .DB_CYCLES(DB)) dut_narrow (
        .CLOCK_50 (clk),
        .RST      (rst),
        .data_in  (data[W_NARROW-1:0]),
        .load     (load),
        .page_btn (btn),
        .lzb_mode (lzb),
        .hex_out  (hex_n),
        .page_idx (page_n)
    );

    // ---------------- reference model state ----------------
    logic [63:0] m_cap_w, m_cap_n;
    int          m_page_w, m_page_n;
    logic [55:0] m_hex_w, m_hex_n;
    bit          m_stable;
    bit          line[$];   // button samples on their way through the synchroniser
    bit          win[$];    // most recent DB synchronised samples
    int          press_count;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected display for a value of the given width on the given page.
    function automatic logic [55:0] model_hex(input logic [63:0] v, input int width,
                                              input int page, input bit lzb_on);
        int          nib [NUM_DIGITS];
        int          hi;
        int          pos;
        logic [55:0] r;
        hi = 0;
        r  = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nib[d] = 0;
            for (int b = 0; b < 4; b++) begin
                pos = 4 * (page * NUM_DIGITS + d) + b;
                if (pos < width) begin
                    if (v[pos]) nib[d] += (1 << b);
                end
            end
            if (nib[d] != 0) hi = d;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r[7*d +: 7] = (lzb_on && d > hi) ? 7'h7F : SEG[nib[d]];
        end
        return r;
    endfunction

    function automatic bit lzb_effective(input logic req);
`ifdef HEX_LZB_EN
        return req;
`else
        return 1'b0 && req;
`endif
    endfunction

    task automatic model_reset_state();
        m_cap_w  = '0;
        m_cap_n  = '0;
        m_page_w = 0;
        m_page_n = 0;
        m_stable = 1'b1;
        line.delete();
        line.push_back(1'b1);
        line.push_back(1'b1);
        win.delete();
    endtask

    // Advance the model by one rising edge using the inputs the DUTs see.
    task automatic model_edge();
        bit s;
        bit all_differ;
        bit press;
        if (rst) begin
            model_reset_state();
            m_hex_w = {NUM_DIGITS{7'h7F}};
            m_hex_n = {NUM_DIGITS{7'h7F}};
        end else begin
            m_hex_w = model_hex(m_cap_w, W_WIDE,   m_page_w, lzb_effective(lzb));
            m_hex_n = model_hex(m_cap_n, W_NARROW, m_page_n, lzb_effective(lzb));

            s = line[0];
            void'(line.pop_front());
            line.push_back(btn);

            win.push_back(s);
            if (win.size() > DB) void'(win.pop_front());
            press = 1'b0;
            if (win.size() == DB) begin
                all_differ = 1'b1;
                foreach (win[i]) if (win[i] == m_stable) all_differ = 1'b0;
                if (all_differ) begin
                    press    = m_stable;   // only a 1->0 change is a press
                    m_stable = ~m_stable;
                end
            end

            if (load) begin
                m_cap_w = data;
                m_cap_n = {24'h0, data[W_NARROW-1:0]};
            end
            if (press) begin
                m_page_w = (m_page_w + 1) % PAGES_WIDE;
                m_page_n = (m_page_n + 1) % PAGES_NARROW;
                press_count++;
            end
        end
    endtask

    // One clock: model the edge, then compare all outputs on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("hex_wide",    {8'h0, hex_w},  {8'h0, m_hex_w});
        check("hex_narrow",  {8'h0, hex_n},  {8'h0, m_hex_n});
        check("page_wide",   64'(page_w),    64'(m_page_w));
        check("page_narrow", 64'(page_n),    64'(m_page_n));
    endtask

    task automatic press_and_release();
        btn = 1'b0;
        repeat (10) cycle();
        btn = 1'b1;
        repeat (8) cycle();
    endtask

    localparam logic [55:0] S1_PAGE0 = {7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] S1_PAGE1 = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    localparam logic [55:0] ZEROS    = {NUM_DIGITS{7'h40}};
    localparam logic [55:0] BLANKS   = {NUM_DIGITS{7'h7F}};

    initial begin
        int pc;
        int run;

        rst  = 1'b1;
        load = 1'b0;
        btn  = 1'b1;
        lzb  = 1'b0;
        data = '0;
        press_count = 0;
        model_reset_state();
        m_hex_w = BLANKS;
        m_hex_n = BLANKS;

        // Reset for two cycles: blank display, page 0.
        repeat (2) cycle();
        check("reset_blank", {8'h0, hex_w}, {8'h0, BLANKS});
        rst = 1'b0;
        cycle();
        check("post_reset_zero", {8'h0, hex_w}, {8'h0, ZEROS});

        // Scenario 1: one-cycle load, visible two edges later.
        load = 1'b1;
        data = 64'h0123_4567_89AB_CDEF;
        cycle();
        load = 1'b0;
        cycle();
        check("s1_display", {8'h0, hex_w}, {8'h0, S1_PAGE0});
        check("s1_page", 64'(page_w), 64'd0);

        // Scenario 2: held press advances once; second press wraps.
        btn = 1'b0;
        repeat (10) cycle();
        check("s2_page1", 64'(page_w), 64'd1);
        check("s2_display", {8'h0, hex_w}, {8'h0, S1_PAGE1});
        btn = 1'b1;
        repeat (8) cycle();
        press_and_release();
        check("s2_wrap", 64'(page_w), 64'd0);

        // Scenario 3: bounce shorter than the debounce window is ignored.
        pc = press_count;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (2) cycle();
        end
        btn = 1'b1;
        repeat (8) cycle();
        check("s3_page", 64'(page_w), 64'd0);
        check("s3_no_press", 64'(press_count - pc), 64'd0);

        // Scenario 4: data changes without load leave the display alone.
        data = '1;
        repeat (4) cycle();
        check("s4_hold", {8'h0, hex_w}, {8'h0, S1_PAGE0});

        // Scenario 5: narrow width (zero-extended top page) and blanking.
        load = 1'b1;
        data = 64'h0000_00AB_0000_0000;
        cycle();
        load = 1'b0;
        press_and_release();
        check("s5_narrow_page1", {8'h0, hex_n}, {8'h0, {{6{7'h40}}, 7'h08, 7'h03}});
        press_and_release();
        lzb  = 1'b1;
        load = 1'b1;
        data = 64'd5;
        cycle();
        load = 1'b0;
        repeat (2) cycle();
`ifdef HEX_LZB_EN
        check("s5_lzb_five", {8'h0, hex_w}, {8'h0, {{7{7'h7F}}, 7'h12}});
`else
        check("s5_lzb_five", {8'h0, hex_w}, {8'h0, {{7{7'h40}}, 7'h12}});
`endif
        load = 1'b1;
        data = 64'd0;
        cycle();
        load = 1'b0;
        repeat (2) cycle();
`ifdef HEX_LZB_EN
        check("s5_lzb_zero", {8'h0, hex_w}, {8'h0, {{7{7'h7F}}, 7'h40}});
`else
        check("s5_lzb_zero", {8'h0, hex_w}, {8'h0, ZEROS});
`endif
        lzb = 1'b0;

        // Scenario 6: reset in the middle of a held press.
        load = 1'b1;
        data = 64'h0123_4567_89AB_CDEF;
        cycle();
        load = 1'b0;
        btn  = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        check("s6_reset_blank", {8'h0, hex_w}, {8'h0, BLANKS});
        check("s6_reset_page", 64'(page_w), 64'd0);
        rst = 1'b0;
        pc  = press_count;
        cycle();
        check("s6_first_after", {8'h0, hex_w}, {8'h0, ZEROS});
        repeat (11) cycle();
        check("s6_one_advance", 64'(page_w), 64'd1);
        repeat (10) cycle();
        check("s6_still_one", 64'(page_w), 64'd1);
        check("s6_press_count", 64'(press_count - pc), 64'd1);
        btn = 1'b1;
        repeat (8) cycle();

        // Random traffic against the model.
        run = 0;
        for (int i = 0; i < 500; i++) begin
            load = ($urandom_range(3) == 0);
            data = {$urandom, $urandom};
            lzb  = $urandom_range(1);
            rst  = ($urandom_range(99) == 0);
            if (run == 0) begin
                btn = ~btn;
                run = $urandom_range(8, 1);
            end
            run--;
            cycle();
        end
        rst = 1'b0;
        btn = 1'b1;
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
